// File: rtl/chacha_block_core.sv
// ChaCha block function engine behind a byte-serial valid/ready interface.
// One quarter-round per cycle; round count and feed-forward are build-time parameters.
module chacha_block_core #(
   parameter int ROUNDS   = 20,
   parameter bit FEED_FWD = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       start,
   output logic       busy,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       done
);

   // state     | meaning
   // S_IDLE    | waiting for the first input byte
   // S_LOAD    | collecting the remaining input bytes
   // S_LOADED  | full state held, waiting for start
   // S_ROUND   | one quarter-round per cycle
   // S_FEED    | optional add of the saved input state
   // S_UNLOAD  | streaming the 64 keystream bytes

   localparam int DR_N = ROUNDS / 2;
   localparam int DR_W = (DR_N > 1) ? $clog2(DR_N) : 1;
   localparam logic [DR_W-1:0] DR_LAST = DR_W'(DR_N - 1);

   generate
      if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_bad_rounds
         $error("chacha_block_core: ROUNDS must be even and >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOADED, S_ROUND, S_FEED, S_UNLOAD
   } state_t;

   state_t            state;
   logic [31:0]       st [16];
   logic [31:0]       sv [16];
   logic [5:0]        cnt;
   logic [2:0]        q;
   logic [DR_W-1:0]   dr;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // q[2]=0 selects a column, q[2]=1 a diagonal (b,c,d rotated by 1,2,3 within their rows)
   logic [1:0] qi;
   logic [3:0] ia, ib, ic, id;
   always_comb begin
      qi = q[1:0];
      ia = {2'b00, qi};
      if (!q[2]) begin
         ib = {2'b01, qi};
         ic = {2'b10, qi};
         id = {2'b11, qi};
      end else begin
         ib = {2'b01, qi + 2'd1};
         ic = {2'b10, qi + 2'd2};
         id = {2'b11, qi + 2'd3};
      end
   end

   logic [31:0] a0, b0, c0, d0, a1, b1, c1, d1, a2, b2, c2, d2;
   always_comb begin
      a0 = st[ia];
      b0 = st[ib];
      c0 = st[ic];
      d0 = st[id];
      a1 = a0 + b0;
      d1 = rotl(d0 ^ a1, 16);
      c1 = c0 + d1;
      b1 = rotl(b0 ^ c1, 12);
      a2 = a1 + b1;
      d2 = rotl(d1 ^ a2, 8);
      c2 = c1 + d2;
      b2 = rotl(b1 ^ c2, 7);
   end

   logic [31:0] out_word;
   always_comb begin
      out_word = st[cnt[5:2]];
      out_data = out_valid ? out_word[{cnt[1:0], 3'b000} +: 8] : 8'h00;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 6'd0;
         q         <= 3'd0;
         dr        <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            st[i] <= 32'd0;
            sv[i] <= 32'd0;
         end
      end else if (ena) begin
         done <= 1'b0;
         unique case (state)
            S_IDLE, S_LOAD: begin
               if (in_valid && in_ready) begin
                  st[cnt[5:2]][{cnt[1:0], 3'b000} +: 8] <= in_data;
                  cnt   <= cnt + 6'd1;
                  state <= S_LOAD;
                  if (cnt == 6'd63) begin
                     // the last byte lands in word 15 in this same edge, so patch it into the copy
                     for (int i = 0; i < 16; i++) sv[i] <= st[i];
                     sv[15][31:24] <= in_data;
                     state    <= S_LOADED;
                     in_ready <= 1'b0;
                  end
               end
            end
            S_LOADED: begin
               if (start) begin
                  state <= S_ROUND;
                  busy  <= 1'b1;
                  q     <= 3'd0;
                  dr    <= '0;
               end
            end
            S_ROUND: begin
               st[ia] <= a2;
               st[ib] <= b2;
               st[ic] <= c2;
               st[id] <= d2;
               q      <= q + 3'd1;
               if (q == 3'd7) begin
                  if (dr == DR_LAST) begin
                     dr    <= '0;
                     state <= S_FEED;
                  end else begin
                     dr <= dr + 1'b1;
                  end
               end
            end
            S_FEED: begin
               if (FEED_FWD) begin
                  for (int i = 0; i < 16; i++) st[i] <= st[i] + sv[i];
               end
               state <= S_UNLOAD;
               busy  <= 1'b0;
            end
            S_UNLOAD: begin
               // out_valid rises one cycle after entry, giving the 4*ROUNDS+2 start-to-data latency
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd63) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     in_ready  <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 block, stall, zero state, ChaCha8 build,
// ignored start/in_valid, and reset mid-round followed by an ena-toggled reload.
module tb_chacha_block_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ena = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   int         sel = 0;

   logic       in_ready_v [3];
   logic       busy_v     [3];
   logic       out_valid_v[3];
   logic       done_v     [3];
   logic [7:0] out_data_v [3];

   logic       in_ready, busy, out_valid, done;
   logic [7:0] out_data;

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] blk   [16];
   logic [7:0]  exp_b [64];
   logic [31:0] mx    [16];

   logic [31:0] rfc_in [16] = '{
      32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
      32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};

   logic [7:0] rfc_out [64] = '{
      8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
      8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4,
      8'hc7, 8'hd1, 8'hf4, 8'hc7, 8'h33, 8'hc0, 8'h68, 8'h03,
      8'h04, 8'h22, 8'haa, 8'h9a, 8'hc3, 8'hd4, 8'h6c, 8'h4e,
      8'hd2, 8'h82, 8'h64, 8'h46, 8'h07, 8'h9f, 8'haa, 8'h09,
      8'h14, 8'hc2, 8'hd7, 8'h05, 8'hd9, 8'h8b, 8'h02, 8'ha2,
      8'hb5, 8'h12, 8'h9c, 8'hd1, 8'hde, 8'h16, 8'h4e, 8'hb9,
      8'hcb, 8'hd0, 8'h83, 8'he8, 8'ha2, 8'h50, 8'h3c, 8'h4e};

   always #5 clk = ~clk;

   chacha_block_core #(.ROUNDS(20), .FEED_FWD(1'b1)) u_dut20 (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .in_valid(in_valid && sel == 0), .in_data(in_data), .in_ready(in_ready_v[0]),
      .start(start && sel == 0), .busy(busy_v[0]),
      .out_valid(out_valid_v[0]), .out_data(out_data_v[0]),
      .out_ready(out_ready && sel == 0), .done(done_v[0]));

   chacha_block_core #(.ROUNDS(20), .FEED_FWD(1'b0)) u_dut_raw (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .in_valid(in_valid && sel == 1), .in_data(in_data), .in_ready(in_ready_v[1]),
      .start(start && sel == 1), .busy(busy_v[1]),
      .out_valid(out_valid_v[1]), .out_data(out_data_v[1]),
      .out_ready(out_ready && sel == 1), .done(done_v[1]));

   chacha_block_core #(.ROUNDS(8), .FEED_FWD(1'b1)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .in_valid(in_valid && sel == 2), .in_data(in_data), .in_ready(in_ready_v[2]),
      .start(start && sel == 2), .busy(busy_v[2]),
      .out_valid(out_valid_v[2]), .out_data(out_data_v[2]),
      .out_ready(out_ready && sel == 2), .done(done_v[2]));

   always_comb begin
      in_ready  = in_ready_v[sel];
      busy      = busy_v[sel];
      out_valid = out_valid_v[sel];
      done      = done_v[sel];
      out_data  = out_data_v[sel];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   // Reference block function, written straight from the quarter-round definition
   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic void qr(input int a, input int b, input int c, input int d);
      mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 16);
      mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 12);
      mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 8);
      mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 7);
   endfunction

   function automatic void ref_block(input int rounds, input bit ff);
      logic [31:0] w;
      for (int i = 0; i < 16; i++) mx[i] = blk[i];
      for (int r = 0; r < rounds / 2; r++) begin
         qr(0, 4, 8, 12); qr(1, 5, 9, 13); qr(2, 6, 10, 14); qr(3, 7, 11, 15);
         qr(0, 5, 10, 15); qr(1, 6, 11, 12); qr(2, 7, 8, 13); qr(3, 4, 9, 14);
      end
      for (int i = 0; i < 16; i++) begin
         w = ff ? mx[i] + blk[i] : mx[i];
         for (int b = 0; b < 4; b++) exp_b[4*i+b] = w[8*b +: 8];
      end
   endfunction

   task automatic load_bytes(input int first, input int last, input bit toggle_ena);
      logic [31:0] w;
      for (int k = first; k < last; k++) begin
         w        = blk[k / 4];
         in_data  = w[8*(k % 4) +: 8];
         in_valid = 1'b1;
         if (toggle_ena && (k % 7) == 3) begin
            ena = 1'b0;
            repeat (3) @(negedge clk);
            ena = 1'b1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic run_block(input string tag, input int want_lat, input bit poke);
      int lat;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         in_valid = 1'b1;
         in_data  = 8'haa;
      end
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(negedge clk);
         lat++;
         if (lat == 10) begin
            chk({tag, "_busy_round"}, busy, 1);
            chk({tag, "_in_ready_round"}, in_ready, 0);
         end
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, lat, want_lat);
   endtask

   task automatic unload(input string tag, input int stall_at, input int stall_len);
      for (int j = 0; j < 64; j++) begin
         chk($sformatf("%s_byte%0d", tag, j), out_data, exp_b[j]);
         if (j == stall_at) begin
            out_ready = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               chk($sformatf("%s_stall_valid", tag), out_valid, 1);
               chk($sformatf("%s_stall_data", tag), out_data, exp_b[j]);
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_valid_end"}, out_valid, 0);
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_in_ready_idle"}, in_ready, 1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_done"}, done, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // RFC vector, with start pulsed in IDLE and mid-LOAD, and in_valid poked during ROUND
      sel = 0;
      blk = rfc_in;
      exp_b = rfc_out;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("idle_start_busy", busy, 0);
      chk("idle_start_in_ready", in_ready, 1);
      load_bytes(0, 10, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("load_start_busy", busy, 0);
      chk("load_start_in_ready", in_ready, 1);
      load_bytes(10, 64, 1'b0);
      chk("loaded_in_ready", in_ready, 0);
      run_block("rfc", 82, 1'b1);
      unload("rfc", -1, 0);

      // Same block with a 20-cycle consumer stall on byte 5
      load_bytes(0, 64, 1'b0);
      run_block("stall", 82, 1'b0);
      unload("stall", 5, 20);

      // All-zero state through the raw permutation build
      sel = 1;
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      for (int j = 0; j < 64; j++) exp_b[j] = 8'h00;
      load_bytes(0, 64, 1'b0);
      run_block("zero", 82, 1'b0);
      unload("zero", -1, 0);

      // ChaCha8 build against the reference model
      sel = 2;
      blk = rfc_in;
      ref_block(8, 1'b1);
      load_bytes(0, 64, 1'b0);
      run_block("r8", 34, 1'b0);
      unload("r8", -1, 0);

      // Reset mid-ROUND, then a reload with ena toggling
      sel = 0;
      blk = rfc_in;
      exp_b = rfc_out;
      load_bytes(0, 64, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      #3 rst_n = 1'b0;
      #1 chk_reset_outputs("mid_round_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load_bytes(0, 64, 1'b1);
      chk("reload_in_ready", in_ready, 0);
      run_block("reload", 82, 1'b0);
      unload("reload", -1, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
